exec_mc_sched: RTL and testbench
================================

EXEC_MC_SCHED -- requirements
Module: exec_mc_sched

Interface
REQ-001 The block SHALL use clock clk and reset rst, synchronous, active-high.
REQ-002 The block SHALL expose these ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; blocks issue
- issue  in  1  exec-stage op valid
- kind  in  2  0=ALU/none, 1=FPU, 2=UART_IN, 3=UART_OUT
- ctl  in  5  FPU opcode
- op1, op2  in  32  forwarded operands
- fpu_en  out  1  FPU start pulse
- fpu_ctl  out  5  opcode to FPU
- fpu_a, fpu_b  out  32  operands to FPU
- fpu_ready  in  1  FPU done
- fpu_out  in  32  FPU result
- rx_ready  in  1  one-cycle byte-received strobe
- rx_data  in  8  received byte
- tx_start  out  1  one-cycle UART transmit start
- tx_data  out  8  byte to transmit
- tx_busy  in  1  transmitter busy
- wait_exec  out  1  hold exec stage
- done  out  1  multi-cycle op completes this cycle
- result  out  32  completed op result, valid when done=1
- rx_overflow  out  1  sticky; RX byte dropped
- timeout  out  1  sticky; watchdog abort (0 when feature compiled out)

Function
REQ-003 The block SHALL use states IDLE, FPU_WAIT, RX_WAIT and TX_WAIT; an accepted issue is issue=1, state=IDLE, stall=0.
REQ-004 On accepted kind=0, the block SHALL leave state IDLE with no wait or done.
REQ-005 On accepted kind=1, the block SHALL pulse fpu_en that cycle, latch ctl into ctl_q, and enter FPU_WAIT.
REQ-006 fpu_ctl SHALL equal ctl_q in FPU_WAIT and ctl otherwise; fpu_a and fpu_b SHALL pass op1 and op2 through.
REQ-007 In FPU_WAIT, wait_exec SHALL equal ~fpu_ready.
- When fpu_ready=1: done=1, result=fpu_out, next state IDLE.
REQ-008 On accepted kind=2, the block SHALL enter RX_WAIT.
REQ-009 In RX_WAIT with the FIFO non-empty, the block SHALL pop the head, assert done=1 with result={24'b0,head}, and return to IDLE.
REQ-010 In RX_WAIT with the FIFO empty and rx_ready=1, the byte SHALL bypass the FIFO and complete the op that cycle.
REQ-011 In RX_WAIT with the FIFO empty and rx_ready=0, wait_exec SHALL be 1.
REQ-012 On accepted kind=3, the block SHALL latch op1[7:0] into tx_data and enter TX_WAIT.
REQ-013 In TX_WAIT while tx_busy=1, wait_exec SHALL be 1.
REQ-014 In the first TX_WAIT cycle with tx_busy=0, the block SHALL pulse tx_start, assert done=1 with result=0, and return to IDLE.
REQ-015 The RX FIFO SHALL hold 4 entries, pushing rx_data on rx_ready except on a bypass.
- Pointers wrap modulo 4.
REQ-016 On push when full with no simultaneous pop, the byte SHALL be dropped and rx_overflow set; push and pop in the same cycle when full SHALL both occur with no overflow.
REQ-017 wait_exec SHALL be 0 in IDLE and in every done cycle.
REQ-018 stall SHALL be ignored in the wait states; an in-flight op continues.
REQ-019 issue outside IDLE SHALL be ignored.

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL force: state IDLE, FIFO empty, ctl_q=0, tx_data=0, rx_overflow=0, timeout=0, watchdog counter=0.
- Combinational outputs fpu_en, tx_start, wait_exec and done SHALL be 0 while rst=1.
REQ-021 Reset mid-operation SHALL abandon the op with no done or tx_start.

Configuration
REQ-022 With EXEC_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL clear on wait-state entry and increment each wait-state cycle without completion.
- At 16'hFFFF: force IDLE, assert done=1 with result=32'hFFFFFFFF, set timeout.
REQ-023 Without EXEC_SCHED_TIMEOUT_EN, the block SHALL have no counter, timeout SHALL be tied 0, and the wait states SHALL persist indefinitely.

Verification
REQ-024 FPU path: issue kind=1 ctl=5, fpu_ready after 3 cycles with fpu_out=32'h3F800000 -> single fpu_en; wait_exec=1 for 3 cycles; done with result 32'h3F800000; fpu_ctl=5 throughout.
REQ-025 RX buffering: push 0x41,0x42 while IDLE, then two kind=2 issues -> results 0x41 then 0x42 with no wait cycles.
REQ-026 RX overflow and bypass:
- Push 5 bytes while IDLE -> rx_overflow=1 and FIFO holds the first 4.
- Empty FIFO, kind=2, rx_ready arrives 10 cycles later -> done in the rx_ready cycle with no FIFO push.
REQ-027 TX: tx_busy=1 for 4 cycles, then kind=3 with op1=32'h1234_5678 -> tx_start once, tx_data=0x78, after busy falls.
REQ-028 Corner cases:
- stall=1 with issue -> no fpu_en and no state change.
- rst mid-FPU_WAIT -> IDLE with no done.
- With EXEC_SCHED_TIMEOUT_EN, kind=1 and fpu_ready never asserted -> done with result 32'hFFFFFFFF and timeout=1 after 65535 wait cycles.

Source files
------------

// File: rtl/exec_mc_sched_if.sv
// exec_mc_sched_if: exec-stage, FPU and UART signal bundle for exec_mc_sched
interface exec_mc_sched_if;
    logic        stall;
    logic        issue;
    logic [1:0]  kind;
    logic [4:0]  ctl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        fpu_en;
    logic [4:0]  fpu_ctl;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_ready;
    logic [31:0] fpu_out;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        wait_exec;
    logic        done;
    logic [31:0] result;
    logic        rx_overflow;
    logic        timeout;

    modport slave (
        input  stall, issue, kind, ctl, op1, op2, fpu_ready, fpu_out, rx_ready, rx_data, tx_busy,
        output fpu_en, fpu_ctl, fpu_a, fpu_b, tx_start, tx_data, wait_exec, done, result, rx_overflow, timeout
    );

    modport master (
        output stall, issue, kind, ctl, op1, op2, fpu_ready, fpu_out, rx_ready, rx_data, tx_busy,
        input  fpu_en, fpu_ctl, fpu_a, fpu_b, tx_start, tx_data, wait_exec, done, result, rx_overflow, timeout
    );
endinterface

// File: rtl/exec_mc_sched.sv
// exec_mc_sched: multi-cycle FPU/UART op scheduler with 4-entry RX FIFO; define EXEC_SCHED_TIMEOUT_EN for the watchdog
module exec_mc_sched (
    input logic clk,
    input logic rst,
    exec_mc_sched_if.slave bus
);
    // encoding matches kind so an accepted op maps straight onto its wait state
    typedef enum logic [1:0] {IDLE, FPU_WAIT, RX_WAIT, TX_WAIT} state_t;
    state_t state, state_n;
    logic [4:0] ctl_q;
    logic [7:0] tx_q;
    logic [7:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;
    logic       ovf_q;
    logic       accept, in_wait, empty, full, pop, bypass, push, push_ok, nat_done, to_hit;

    assign accept  = bus.issue && state == IDLE && !bus.stall;
    assign in_wait = state != IDLE;
    assign empty   = cnt == 3'd0;
    assign full    = cnt == 3'd4;
    assign pop     = state == RX_WAIT && !empty;
    assign bypass  = state == RX_WAIT && empty && bus.rx_ready;
    assign push    = bus.rx_ready && !bypass;
    assign push_ok = push && (!full || pop);

    always_comb
        nat_done = state == FPU_WAIT ? bus.fpu_ready :
                   state == RX_WAIT  ? (!empty || bus.rx_ready) :
                   state == TX_WAIT  ? !bus.tx_busy : 1'b0;

`ifdef EXEC_SCHED_TIMEOUT_EN
    logic [15:0] wd;
    logic        to_q;
    always_ff @(posedge clk)
        if (rst || accept)
            wd <= '0;
        else if (in_wait && !nat_done)
            wd <= wd + 16'd1;
    assign to_hit = in_wait && !nat_done && wd == 16'hFFFF;
    always_ff @(posedge clk)
        if (rst)
            to_q <= 1'b0;
        else if (to_hit)
            to_q <= 1'b1;
    assign bus.timeout = to_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb
        state_n = state == IDLE ? (accept ? state_t'(bus.kind) : IDLE) :
                  (nat_done || to_hit) ? IDLE : state;

    always_comb begin
        bus.fpu_en    = !rst && accept && bus.kind == 2'd1;
        bus.tx_start  = !rst && state == TX_WAIT && !bus.tx_busy;
        bus.done      = !rst && (nat_done || to_hit);
        bus.wait_exec = !rst && in_wait && !nat_done && !to_hit;
        bus.fpu_ctl   = state == FPU_WAIT ? ctl_q : bus.ctl;
        bus.result    = to_hit             ? 32'hFFFF_FFFF :
                        state == FPU_WAIT  ? bus.fpu_out :
                        state == RX_WAIT   ? {24'b0, empty ? bus.rx_data : fifo[rd_ptr]} : 32'b0;
    end

    assign bus.fpu_a       = bus.op1;
    assign bus.fpu_b       = bus.op2;
    assign bus.tx_data     = tx_q;
    assign bus.rx_overflow = ovf_q;

    always_ff @(posedge clk)
        if (push_ok)
            fifo[wr_ptr] <= bus.rx_data;

    always_ff @(posedge clk)
        if (rst) begin
            ctl_q  <= '0;
            tx_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept && bus.kind == 2'd1)
                ctl_q <= bus.ctl;
            if (accept && bus.kind == 2'd3)
                tx_q <= bus.op1[7:0];
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt + {2'b0, push_ok} - {2'b0, pop};
            if (push && !push_ok)
                ovf_q <= 1'b1;
        end
endmodule

// File: tb/tb_exec_mc_sched.sv
// tb_exec_mc_sched: directed self-checking bench for exec_mc_sched
module tb_exec_mc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    exec_mc_sched_if bus ();
    exec_mc_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        #4;
    endtask

    task automatic push(input logic [7:0] d);
        bus.rx_ready = 1'b1;
        bus.rx_data  = d;
        cyc;
        bus.rx_ready = 1'b0;
    endtask

    task automatic rx_op(input logic [7:0] exp);
        bus.issue = 1'b1;
        bus.kind  = 2'd2;
        mid;
        chk("rx_accept_wait", bus.wait_exec, 0);
        cyc;
        bus.issue = 1'b0;
        mid;
        chk("rx_done", bus.done, 1);
        chk("rx_result", bus.result, {24'b0, exp});
        chk("rx_wait", bus.wait_exec, 0);
        cyc;
    endtask

    initial begin
        bus.stall = 0; bus.issue = 1; bus.kind = 1; bus.ctl = 0;
        bus.op1 = 0; bus.op2 = 0; bus.fpu_ready = 0; bus.fpu_out = 0;
        bus.rx_ready = 0; bus.rx_data = 0; bus.tx_busy = 0;
        cyc; cyc; mid;
        chk("rst_fpu_en", bus.fpu_en, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wait", bus.wait_exec, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_ovf", bus.rx_overflow, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        cyc;
        rst = 0; bus.issue = 0; bus.kind = 0;

        // stalled issue is not accepted
        bus.stall = 1; bus.issue = 1; bus.kind = 1; bus.ctl = 5; mid;
        chk("stall_fpu_en", bus.fpu_en, 0);
        cyc;
        bus.stall = 0; bus.issue = 0; mid;
        chk("stall_idle", bus.wait_exec, 0);
        cyc;

        bus.issue = 1; bus.kind = 0; mid;
        chk("alu_done", bus.done, 0);
        chk("alu_fpu_en", bus.fpu_en, 0);
        cyc;
        bus.issue = 0; mid;
        chk("alu_idle", bus.wait_exec, 0);
        cyc;

        // FPU op, ready after 3 wait cycles
        bus.issue = 1; bus.kind = 1; bus.ctl = 5;
        bus.op1 = 32'hAAAA_0001; bus.op2 = 32'h5555_0002; mid;
        chk("fpu_en", bus.fpu_en, 1);
        chk("fpu_ctl_issue", bus.fpu_ctl, 5);
        chk("fpu_a", bus.fpu_a, 32'hAAAA_0001);
        chk("fpu_b", bus.fpu_b, 32'h5555_0002);
        chk("fpu_issue_wait", bus.wait_exec, 0);
        cyc;
        bus.issue = 0; bus.ctl = 9;
        for (int i = 0; i < 3; i++) begin
            bus.issue = (i == 1);
            mid;
            chk("fpu_wait", bus.wait_exec, 1);
            chk("fpu_en_once", bus.fpu_en, 0);
            chk("fpu_ctl_held", bus.fpu_ctl, 5);
            chk("fpu_not_done", bus.done, 0);
            cyc;
        end
        bus.issue = 0; bus.stall = 1; bus.fpu_ready = 1; bus.fpu_out = 32'h3F80_0000; mid;
        chk("fpu_done", bus.done, 1);
        chk("fpu_result", bus.result, 32'h3F80_0000);
        chk("fpu_done_wait", bus.wait_exec, 0);
        chk("fpu_ctl_done", bus.fpu_ctl, 5);
        cyc;
        bus.stall = 0; bus.fpu_ready = 0; mid;
        chk("fpu_after_done", bus.done, 0);
        chk("fpu_after_wait", bus.wait_exec, 0);
        chk("fpu_ctl_pass", bus.fpu_ctl, 9);
        cyc;

        push(8'h41); push(8'h42);
        rx_op(8'h41); rx_op(8'h42);

        // 5 pushes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        mid;
        chk("ovf_set", bus.rx_overflow, 1);
        cyc;
        for (int i = 0; i < 4; i++) rx_op(8'h10 + 8'(i));

        // bypass: FIFO empty, byte arrives 10 cycles after issue
        bus.issue = 1; bus.kind = 2; mid; cyc;
        bus.issue = 0;
        for (int i = 0; i < 9; i++) begin
            mid;
            chk("rx_empty_wait", bus.wait_exec, 1);
            chk("rx_empty_done", bus.done, 0);
            cyc;
        end
        bus.rx_ready = 1; bus.rx_data = 8'h5A; mid;
        chk("byp_done", bus.done, 1);
        chk("byp_result", bus.result, 32'h5A);
        chk("byp_wait", bus.wait_exec, 0);
        cyc;
        bus.rx_ready = 0;
        bus.issue = 1; bus.kind = 2; mid; cyc;
        bus.issue = 0; mid;
        chk("byp_no_push", bus.wait_exec, 1);
        cyc;
        bus.rx_ready = 1; bus.rx_data = 8'h66; mid;
        chk("byp2_result", bus.result, 32'h66);
        chk("ovf_sticky", bus.rx_overflow, 1);
        cyc;
        bus.rx_ready = 0;

        // reset in FPU_WAIT abandons the op
        bus.issue = 1; bus.kind = 1; mid; cyc;
        bus.issue = 0; mid;
        chk("rstfpu_wait", bus.wait_exec, 1);
        cyc;
        rst = 1; bus.fpu_ready = 1; mid;
        chk("rstfpu_done", bus.done, 0);
        chk("rstfpu_wait_rst", bus.wait_exec, 0);
        cyc;
        rst = 0; mid;
        chk("rstfpu_idle_done", bus.done, 0);
        chk("rstfpu_idle_wait", bus.wait_exec, 0);
        chk("rst_ovf_clear", bus.rx_overflow, 0);
        cyc;
        bus.fpu_ready = 0;

        // simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        bus.issue = 1; bus.kind = 2; mid; cyc;
        bus.issue = 0; bus.rx_ready = 1; bus.rx_data = 8'h24; mid;
        chk("full_pp_done", bus.done, 1);
        chk("full_pp_result", bus.result, 32'h20);
        cyc;
        bus.rx_ready = 0; mid;
        chk("full_pp_no_ovf", bus.rx_overflow, 0);
        cyc;
        for (int i = 1; i < 5; i++) rx_op(8'h20 + 8'(i));

        // TX waits for busy to fall
        bus.tx_busy = 1; bus.issue = 1; bus.kind = 3; bus.op1 = 32'h1234_5678; mid;
        chk("tx_issue_start", bus.tx_start, 0);
        cyc;
        bus.issue = 0; bus.op1 = 0;
        for (int i = 0; i < 4; i++) begin
            mid;
            chk("tx_busy_wait", bus.wait_exec, 1);
            chk("tx_busy_start", bus.tx_start, 0);
            chk("tx_data", bus.tx_data, 32'h78);
            cyc;
        end
        bus.tx_busy = 0; mid;
        chk("tx_start", bus.tx_start, 1);
        chk("tx_done", bus.done, 1);
        chk("tx_result", bus.result, 0);
        chk("tx_done_wait", bus.wait_exec, 0);
        cyc;
        mid;
        chk("tx_start_once", bus.tx_start, 0);
        chk("tx_after_done", bus.done, 0);
        cyc;

        // reset in TX_WAIT suppresses tx_start
        bus.tx_busy = 1; bus.issue = 1; bus.kind = 3; bus.op1 = 32'h99; mid; cyc;
        bus.issue = 0; bus.tx_busy = 0; rst = 1; mid;
        chk("rsttx_start", bus.tx_start, 0);
        chk("rsttx_done", bus.done, 0);
        cyc;
        rst = 0; mid;
        chk("rsttx_idle_start", bus.tx_start, 0);
        chk("rsttx_data", bus.tx_data, 0);
        cyc;

`ifdef EXEC_SCHED_TIMEOUT_EN
        bus.issue = 1; bus.kind = 1; mid; cyc;
        bus.issue = 0;
        repeat (65534) cyc;
        mid;
        chk("to_pre_wait", bus.wait_exec, 1);
        chk("to_pre_done", bus.done, 0);
        cyc;
        mid;
        chk("to_done", bus.done, 1);
        chk("to_result", bus.result, 32'hFFFF_FFFF);
        chk("to_wait", bus.wait_exec, 0);
        cyc;
        mid;
        chk("to_flag", bus.timeout, 1);
        chk("to_idle", bus.wait_exec, 0);
        cyc;
`else
        bus.issue = 1; bus.kind = 1; mid; cyc;
        bus.issue = 0;
        repeat (100) cyc;
        mid;
        chk("noto_wait", bus.wait_exec, 1);
        chk("noto_flag", bus.timeout, 0);
        cyc;
        bus.fpu_ready = 1; bus.fpu_out = 32'h1; mid;
        chk("noto_done", bus.done, 1);
        cyc;
        bus.fpu_ready = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
